// File: rtl/audio_cmd_sequencer_pkg.sv
// Shared types for the audio command sequencer: AHB transfer codes,
// sequencer FSM states and the buffered command layout.
package audio_cmd_sequencer_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] data;
    } audio_cmd_t;

    localparam int CMD_W = $bits(audio_cmd_t);

endpackage

// File: rtl/audio_cmd_fifo.sv
// Synchronous command FIFO with flush; full/empty judged on registered count.
// Ports: clk, rst_n, push/push_data, pop/pop_data (head), flush, full, empty, count.
module audio_cmd_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are AW bits wide, so they wrap modulo DEPTH.
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (do_pop && !do_push)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/audio_cmd_sequencer.sv
// Arbitrates game-logic sound commands into a FIFO and issues each as one
// AHB-Lite NONSEQ write (address phase, data phase, then a programmable gap).
// Ports: HCLK/HRESETn; req_valid/req_addr/req_data/req_ready per source; flush;
// AHB master outputs HSEL/HADDR/HTRANS/HWRITE/HWDATA; fifo_count; busy.
module audio_cmd_sequencer
    import audio_cmd_sequencer_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_CYCLES = 2,
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic [NUM_SRC-1:0]      req_valid,
    input  logic [NUM_SRC*4-1:0]    req_addr,
    input  logic [NUM_SRC*32-1:0]   req_data,
    output logic [NUM_SRC-1:0]      req_ready,
    input  logic                    flush,
    output logic                    HSEL,
    output logic [3:0]              HADDR,
    output logic [1:0]              HTRANS,
    output logic                    HWRITE,
    output logic [31:0]             HWDATA,
    output logic [CW-1:0]           fifo_count,
    output logic                    busy
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST =
        GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    seq_state_t state;
    seq_state_t next_state;

    audio_cmd_t push_cmd;
    audio_cmd_t head_cmd;
    logic       push;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic       found;

    logic [GW-1:0] gap_cnt;
    logic [31:0]   hold_data;

    logic          hsel_d;
    logic [3:0]    haddr_d;
    logic [1:0]    htrans_d;
    logic          hwrite_d;
    logic [31:0]   hwdata_d;

    // Lowest-index valid source wins; a blocked winner blocks everyone.
    always_comb begin
        req_ready = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (req_valid[i] && !found) begin
                found = 1'b1;
                if (!fifo_full && !flush)
                    req_ready[i] = 1'b1;
            end
        end
    end

    always_comb begin
        push_cmd = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (req_ready[i]) begin
                push_cmd.addr = req_addr[4*i +: 4];
                push_cmd.data = req_data[32*i +: 32];
            end
        end
    end

    assign push = |req_ready;
    assign pop  = (state == ST_IDLE) && !fifo_empty && !flush;
    assign busy = !fifo_empty || (state != ST_IDLE);

    audio_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (HCLK),
        .rst_n     (HRESETn),
        .push      (push),
        .push_data (push_cmd),
        .pop       (pop),
        .pop_data  (head_cmd),
        .flush     (flush),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // State, gap counter, held data and registered bus outputs.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            gap_cnt   <= '0;
            hold_data <= '0;
            HSEL      <= 1'b0;
            HADDR     <= '0;
            HTRANS    <= HTRANS_IDLE;
            HWRITE    <= 1'b0;
            HWDATA    <= '0;
        end else begin
            state <= next_state;
            if (state == ST_GAP && next_state == ST_GAP)
                gap_cnt <= gap_cnt + GW'(1);
            else
                gap_cnt <= '0;
            if (pop)
                hold_data <= head_cmd.data;
            HSEL   <= hsel_d;
            HADDR  <= haddr_d;
            HTRANS <= htrans_d;
            HWRITE <= hwrite_d;
            HWDATA <= hwdata_d;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: if (pop) next_state = ST_ADDR;
            ST_ADDR: next_state = ST_DATA;
            ST_DATA: next_state = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
            ST_GAP:  if (gap_cnt == GAP_LAST) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Outputs are computed from the state being entered so they register
    // alongside it; HADDR and HWDATA hold outside their own phase.
    always_comb begin
        hsel_d   = 1'b0;
        haddr_d  = HADDR;
        htrans_d = HTRANS_IDLE;
        hwrite_d = 1'b0;
        hwdata_d = HWDATA;
        unique case (next_state)
            ST_ADDR: begin
                hsel_d   = 1'b1;
                haddr_d  = head_cmd.addr;
                htrans_d = HTRANS_NONSEQ;
                hwrite_d = 1'b1;
            end
            ST_DATA: hwdata_d = hold_data;
            default: ;
        endcase
    end

endmodule
